// File: rtl/conv_pkg.sv
// Shared constants for the upscaler pixel/weight datapath.
package conv_pkg;

  localparam int PIX_W         = 8;
  localparam int WGT_W         = 9;
  localparam int PROD_W        = 20;
  localparam int NUM_TAPS_DEF  = 9;
  localparam int FRAC_BITS_DEF = 7;
  localparam int ACC_W_DEF     = 24;

  // Output register state: empty/draining vs. holding an untaken pixel.
  typedef enum logic {
    ACCUM = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/conv_tap_accumulator_if.sv
// Product-in / pixel-out handshake bundle for the tap accumulator.
interface conv_tap_accumulator_if;
  import conv_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic signed [PROD_W-1:0] in_product;
  logic                     out_valid;
  logic                     out_ready;
  logic [PIX_W-1:0]         out_pixel;
  logic                     out_sat;

  // Environment side: supplies products, consumes pixels.
  modport master (
    output in_valid, in_product, out_ready,
    input  in_ready, out_valid, out_pixel, out_sat
  );

  // Accumulator side.
  modport slave (
    input  in_valid, in_product, out_ready,
    output in_ready, out_valid, out_pixel, out_sat
  );

endinterface

// File: rtl/conv_tap_accumulator_round_clamp.sv
// Round-half-up, rescale by the weight format, clamp to an unsigned pixel.
module pixel_round_clamp
  import conv_pkg::*;
#(
  parameter int ACC_W     = ACC_W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic signed [ACC_W-1:0] sum,
  output logic [PIX_W-1:0]        pixel,
  output logic                    sat
);

  // One extra bit so adding the rounding half can never wrap.
  localparam int EXT_W = ACC_W + 1;
  localparam logic signed [EXT_W-1:0] HALF    = EXT_W'(1 << (FRAC_BITS - 1));
  localparam logic signed [EXT_W-1:0] MAX_PIX = EXT_W'((1 << PIX_W) - 1);

  logic signed [EXT_W-1:0] biased;
  logic signed [EXT_W-1:0] rounded;

  // Arithmetic shift floors, so +HALF gives round-half-up for both signs.
  always_comb begin
    biased  = EXT_W'(sum) + HALF;
    rounded = biased >>> FRAC_BITS;
    pixel   = rounded[PIX_W-1:0];
    sat     = 1'b0;
    if (rounded[EXT_W-1]) begin
      pixel = '0;
      sat   = 1'b1;
    end else if (rounded > MAX_PIX) begin
      pixel = '1;
      sat   = 1'b1;
    end
  end

endmodule

// File: rtl/conv_tap_accumulator.sv
// Sums NUM_TAPS signed products per output pixel and hands the rounded,
// clamped pixel downstream through a single output register.
module conv_tap_accumulator
  import conv_pkg::*;
#(
  parameter int NUM_TAPS  = NUM_TAPS_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  conv_tap_accumulator_if.slave  bus
);

  localparam int CNT_W = $clog2(NUM_TAPS);
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NUM_TAPS - 1);

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         tap_cnt_q, tap_cnt_d;
  logic [PIX_W-1:0]         pixel_q, pixel_d;
  logic                     sat_q, sat_d;

  logic signed [ACC_W-1:0]  sum;
  logic [PIX_W-1:0]         rc_pixel;
  logic                     rc_sat;
  logic                     accept, last, drain;

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_pixel = pixel_q;
  assign bus.out_sat   = sat_q;

  // Stall only while a finished pixel is held; clear blocks the tap so it is
  // not silently dropped by the abort.
  assign bus.in_ready = ~clear & (~bus.out_valid | bus.out_ready);

  assign accept = bus.in_valid & bus.in_ready;
  assign last   = (tap_cnt_q == LAST_TAP);
  assign drain  = bus.out_valid & bus.out_ready;
  assign sum    = acc_q + ACC_W'(bus.in_product);

  pixel_round_clamp #(
    .ACC_W     (ACC_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_round_clamp (
    .sum   (sum),
    .pixel (rc_pixel),
    .sat   (rc_sat)
  );

  // Next-state: accumulate taps, load the output on the last tap, drain.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    tap_cnt_d = tap_cnt_q;
    pixel_d   = pixel_q;
    sat_d     = sat_q;

    if (drain) state_d = ACCUM;

    if (clear) begin
      acc_d     = '0;
      tap_cnt_d = '0;
    end else if (accept) begin
      if (last) begin
        acc_d     = '0;
        tap_cnt_d = '0;
        pixel_d   = rc_pixel;
        sat_d     = rc_sat;
        state_d   = FULL;
      end else begin
        acc_d     = sum;
        tap_cnt_d = tap_cnt_q + 1'b1;
      end
    end
  end

  // State, accumulator and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      tap_cnt_q <= '0;
      pixel_q   <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      tap_cnt_q <= tap_cnt_d;
      pixel_q   <= pixel_d;
      sat_q     <= sat_d;
    end
  end

endmodule
